mode_st_gen: RTL and testbench

- Parametrised successor of the light-pen screen top-level mode state machine.
- Sequences power-up reset, sleep, a ring of MODE_NUM working modes, and a stop state.
- Adds on-chip synchronisation and debounce of raw buttons, backward stepping, and an idle timeout back to SLEEP.
- Drives the mode code consumed by the display, pen and colour datapaths.

---
 rtl/mode_st_gen.sv | 182 ++++++++++++++++++
 tb/tb_mode_st_gen.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mode_st_gen.sv
// Top-level mode sequencer: button synchronise/debounce, RST/SLEEP/STOP/WORK ring, idle timeout.
// Optional per-mode enable mask selected by defining MODE_SKIP_EN.
module mode_st_gen #(
  parameter int MODE_NUM     = 5,
  parameter int STATE_W      = 3,
  parameter int IDX_W        = 3,
  parameter int DEB_CYCLES   = 20,
  parameter int IDLE_TIMEOUT = 0,
  parameter int IDLE_W       = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_next,
  input  logic               btn_prev,
  input  logic               btn_stop,
  input  logic               rst_ok,
`ifdef MODE_SKIP_EN
  input  logic [MODE_NUM-1:0] mode_en,
`endif
  output logic [STATE_W-1:0] state,
  output logic [IDX_W-1:0]   mode_idx,
  output logic               state_chg
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [IDLE_W-1:0]  IDLE_LAST = IDLE_W'((IDLE_TIMEOUT > 0) ? IDLE_TIMEOUT - 1 : 0);
  localparam logic [STATE_W-1:0] LAST_WORK = STATE_W'(MODE_NUM + 2);
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(MODE_NUM - 1);

  typedef enum logic [STATE_W-1:0] {
    ST_RST   = STATE_W'(0),
    ST_SLEEP = STATE_W'(1),
    ST_STOP  = STATE_W'(2),
    ST_WORK0 = STATE_W'(3)
  } state_e;

  // Nearest enabled mode strictly after k (wrapping); the loop runs far-to-near so the nearest wins.
  function automatic logic [IDX_W-1:0] step_fwd(input logic [IDX_W-1:0] k, input logic [MODE_NUM-1:0] en);
    logic [IDX_W-1:0] res;
    int t;
    res = k;
    for (int i = MODE_NUM; i >= 1; i--) begin
      t = int'(k) + i;
      if (t >= MODE_NUM) t = t - MODE_NUM;
      if (en[t]) res = IDX_W'(t);
    end
    return res;
  endfunction

  function automatic logic [IDX_W-1:0] step_bwd(input logic [IDX_W-1:0] k, input logic [MODE_NUM-1:0] en);
    logic [IDX_W-1:0] res;
    int t;
    res = k;
    for (int i = MODE_NUM; i >= 1; i--) begin
      t = int'(k) - i;
      if (t < 0) t = t + MODE_NUM;
      if (en[t]) res = IDX_W'(t);
    end
    return res;
  endfunction

  function automatic state_e to_work(input logic [IDX_W-1:0] k);
    return state_e'(STATE_W'(k) + STATE_W'(3));
  endfunction

  logic [2:0]          s1_q, s1_d, s2_q, s2_d, deb_q, deb_d, deb_dly_q, deb_dly_d;
  logic [CNT_W-1:0]    cnt_q [3];
  logic [CNT_W-1:0]    cnt_d [3];
  logic [2:0]          evt_s;
  logic [MODE_NUM-1:0] mode_en_s;
  state_e              state_q, state_d;
  logic [IDX_W-1:0]    mode_idx_q, mode_idx_d, work_k_s;
  logic                state_chg_q, state_chg_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic                is_work_s, move_s, en_any_s, timeout_s;

`ifdef MODE_SKIP_EN
  assign mode_en_s = mode_en;
`else
  assign mode_en_s = '1;
`endif

  // Button front end: bit 0 next, bit 1 prev, bit 2 stop.
  always_comb begin
    s1_d      = {btn_stop, btn_prev, btn_next};
    s2_d      = s1_q;
    deb_dly_d = deb_q;
    deb_d     = deb_q;
    for (int b = 0; b < 3; b++) begin
      cnt_d[b] = '0;
      if (s2_q[b] != deb_q[b]) begin
        if (cnt_q[b] == CNT_LAST) begin
          deb_d[b] = s2_q[b];
          cnt_d[b] = '0;
        end else begin
          cnt_d[b] = cnt_q[b] + CNT_W'(1);
        end
      end else begin
        cnt_d[b] = '0;
      end
    end
  end

  assign evt_s     = deb_q & ~deb_dly_q;
  assign move_s    = evt_s[0] ^ evt_s[1];
  assign en_any_s  = |mode_en_s;
  assign is_work_s = (state_q >= ST_WORK0) && (state_q <= LAST_WORK);
  assign work_k_s  = IDX_W'(STATE_W'(state_q) - STATE_W'(3));
  assign timeout_s = (IDLE_TIMEOUT > 0) && (idle_q == IDLE_LAST) && !(|evt_s);

  // Next-state, idle counter and registered output values.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RST: begin
        if (rst_ok) state_d = ST_SLEEP;
        else        state_d = ST_RST;
      end
      ST_SLEEP: begin
        if (evt_s[2])                 state_d = ST_STOP;
        else if (move_s && en_any_s)  state_d = to_work(evt_s[0] ? step_fwd(LAST_IDX, mode_en_s)
                                                                 : step_bwd('0, mode_en_s));
        else                          state_d = ST_SLEEP;
      end
      ST_STOP: begin
        if (evt_s[2]) state_d = ST_RST;
        else          state_d = ST_STOP;
      end
      default: begin
        // A disabled current mode is left before button moves are honoured.
        if (!is_work_s)                   state_d = ST_RST;
        else if (!en_any_s)               state_d = ST_SLEEP;
        else if (evt_s[2])                state_d = ST_STOP;
        else if (!mode_en_s[work_k_s])    state_d = to_work(step_fwd(work_k_s, mode_en_s));
        else if (move_s)                  state_d = to_work(evt_s[0] ? step_fwd(work_k_s, mode_en_s)
                                                                     : step_bwd(work_k_s, mode_en_s));
        else if (timeout_s)               state_d = ST_SLEEP;
        else                              state_d = state_q;
      end
    endcase

    if ((state_d != state_q) || (|evt_s))       idle_d = '0;
    else if (is_work_s && (IDLE_TIMEOUT > 0))   idle_d = idle_q + IDLE_W'(1);
    else                                        idle_d = '0;

    if ((state_d >= ST_WORK0) && (state_d <= LAST_WORK)) mode_idx_d = IDX_W'(STATE_W'(state_d) - STATE_W'(3));
    else                                                 mode_idx_d = '0;

    state_chg_d = (state_d != state_q);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_q        <= '0;
      s2_q        <= '0;
      deb_q       <= '0;
      deb_dly_q   <= '0;
      for (int b = 0; b < 3; b++) cnt_q[b] <= '0;
      state_q     <= ST_RST;
      mode_idx_q  <= '0;
      state_chg_q <= 1'b0;
      idle_q      <= '0;
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      deb_q       <= deb_d;
      deb_dly_q   <= deb_dly_d;
      for (int b = 0; b < 3; b++) cnt_q[b] <= cnt_d[b];
      state_q     <= state_d;
      mode_idx_q  <= mode_idx_d;
      state_chg_q <= state_chg_d;
      idle_q      <= idle_d;
    end
  end

  assign state     = state_q;
  assign mode_idx  = mode_idx_q;
  assign state_chg = state_chg_q;

endmodule

// File: tb/tb_mode_st_gen.sv
// Bench for mode_st_gen: behavioural model checked every cycle, directed literal pins, random phase.
module tb_mode_st_gen;
  localparam int N   = 5;
  localparam int DEB = 4;
  localparam int TO  = 50;

  logic clk = 1'b0;
  logic rst, btn_next, btn_prev, btn_stop, rst_ok;
  logic [N-1:0] mode_en_tb;
  logic [2:0] state, mode_idx;
  logic state_chg;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  mode_st_gen #(.MODE_NUM(N), .STATE_W(3), .IDX_W(3), .DEB_CYCLES(DEB),
                .IDLE_TIMEOUT(TO), .IDLE_W(32)) dut (
    .clk(clk), .rst(rst), .btn_next(btn_next), .btn_prev(btn_prev),
    .btn_stop(btn_stop), .rst_ok(rst_ok),
`ifdef MODE_SKIP_EN
    .mode_en(mode_en_tb),
`endif
    .state(state), .mode_idx(mode_idx), .state_chg(state_chg));

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int m_state = 0, m_idx = 0, m_idle = 0;
  bit m_chg = 1'b0;
  bit m_deb [3];
  bit m_deb_old [3];
  bit m_hist [3][DEB+1];   // m_hist[b][0] = raw sample taken at the previous edge

  function automatic int nearest(int k, int dir, logic [N-1:0] en);
    for (int i = 1; i <= N; i++) begin
      int j;
      j = ((k + dir * i) % N + N) % N;
      if (en[j]) return j;
    end
    return k;
  endfunction

  always @(posedge clk) begin
    bit raw [3];
    bit ev [3];
    bit any, mv, all_diff;
    int ns;
    raw[0] = btn_next; raw[1] = btn_prev; raw[2] = btn_stop;
    if (!rst) begin
      m_state = 0; m_idx = 0; m_chg = 1'b0; m_idle = 0;
      for (int b = 0; b < 3; b++) begin
        m_deb[b] = 1'b0; m_deb_old[b] = 1'b0;
        for (int j = 0; j <= DEB; j++) m_hist[b][j] = 1'b0;
      end
    end else begin
      for (int b = 0; b < 3; b++) ev[b] = m_deb[b] && !m_deb_old[b];
      any = ev[0] | ev[1] | ev[2];
      mv  = ev[0] ^ ev[1];
      ns  = m_state;
      if (m_state == 0) begin
        if (rst_ok) ns = 1;
      end else if (m_state == 1) begin
        if (ev[2]) ns = 2;
        else if (mv && mode_en_tb != 0) ns = 3 + (ev[0] ? nearest(-1, 1, mode_en_tb) : nearest(N, -1, mode_en_tb));
      end else if (m_state == 2) begin
        if (ev[2]) ns = 0;
      end else begin
        int k;
        k = m_state - 3;
        if (mode_en_tb == 0) ns = 1;
        else if (ev[2]) ns = 2;
        else if (!mode_en_tb[k]) ns = 3 + nearest(k, 1, mode_en_tb);
        else if (mv) ns = 3 + nearest(k, ev[0] ? 1 : -1, mode_en_tb);
        else if (m_idle == TO - 1 && !any) ns = 1;
      end
      if (ns != m_state || any) m_idle = 0;
      else if (m_state >= 3) m_idle = m_idle + 1;
      else m_idle = 0;
      m_chg   = (ns != m_state);
      m_state = ns;
      m_idx   = (ns >= 3) ? ns - 3 : 0;
      // debounced level flips once DEB consecutive synchronised samples disagree with it
      for (int b = 0; b < 3; b++) begin
        all_diff = 1'b1;
        for (int j = 1; j <= DEB; j++) if (m_hist[b][j] == m_deb[b]) all_diff = 1'b0;
        m_deb_old[b] = m_deb[b];
        if (all_diff) m_deb[b] = !m_deb[b];
        for (int j = DEB; j >= 1; j--) m_hist[b][j] = m_hist[b][j-1];
        m_hist[b][0] = raw[b];
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("state", 32'(state), 32'(m_state));
      chk("mode_idx", 32'(mode_idx), 32'(m_idx));
      chk("state_chg", 32'(state_chg), 32'(m_chg));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic lit(input string name, input int exp);
    chk(name, 32'(state), 32'(exp));
    chk({name, "_model"}, 32'(m_state), 32'(exp));
  endtask

  task automatic press(input int which);
    btn_next = which[0]; btn_prev = which[1]; btn_stop = which[2];
    cyc(6);
    btn_next = 1'b0; btn_prev = 1'b0; btn_stop = 1'b0;
    cyc(10);
  endtask

  task automatic wait_state(input int s, input int limit);
    int c;
    c = 0;
    while (state !== 3'(s) && c < limit) begin
      cyc(1);
      c++;
    end
    chk("wait_state", 32'(state), 32'(s));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cnt;
    rst = 1'b0; rst_ok = 1'b0; mode_en_tb = '1;
    btn_next = 1'b0; btn_prev = 1'b0; btn_stop = 1'b0;
    cyc(3);
    chk_en = 1'b1;
    lit("reset_state", 0);
    chk("reset_idx", 32'(mode_idx), 32'd0);
    chk("reset_chg", 32'(state_chg), 32'd0);
    rst = 1'b1;
    cyc(10);
    lit("hold_rst", 0);
    rst_ok = 1'b1;
    cyc(1);
    lit("to_sleep", 1);
    chk("chg_pulse", 32'(state_chg), 32'd1);
    cyc(1);
    chk("chg_clear", 32'(state_chg), 32'd0);

    // latency: state updates on the 7th edge counted from the first high sample
    btn_next = 1'b1;
    cyc(6);
    lit("lat_before", 1);
    cyc(1);
    lit("lat_work0", 3);
    chk("lat_idx", 32'(mode_idx), 32'd0);
    btn_next = 1'b0;
    cyc(10);

    press(1); lit("next_4", 4);
    chk("idx_1", 32'(mode_idx), 32'd1);
    press(1); lit("next_5", 5);
    press(1); lit("next_6", 6);
    press(1); lit("next_7", 7);
    chk("idx_4", 32'(mode_idx), 32'd4);
    press(1); lit("wrap_3", 3);
    press(2); lit("prev_wrap_7", 7);
    press(1); lit("next_3b", 3);
    press(1); lit("next_4b", 4);

    // bounces shorter than the debounce window are invisible
    for (int i = 0; i < 5; i++) begin
      btn_next = 1'b1; cyc(2);
      btn_next = 1'b0; cyc(2);
    end
    cyc(8);
    lit("bounce_4", 4);

    press(1); lit("next_5b", 5);
    press(3); lit("cancel_5", 5);
    press(5); lit("stop_2", 2);
    press(1); lit("stop_hold_2", 2);
    rst_ok = 1'b0;
    press(4); lit("stop_rst_0", 0);
    rst_ok = 1'b1;
    cyc(2);
    lit("resleep_1", 1);

    // idle timeout: SLEEP exactly TO cycles after entry
    btn_next = 1'b1;
    wait_state(3, 20);
    btn_next = 1'b0;
    cnt = 0;
    while (state !== 3'd1 && cnt < 100) begin
      cyc(1);
      cnt++;
    end
    chk("idle_cycles", 32'(cnt), 32'd50);
    lit("idle_sleep", 1);

    // event in the last idle cycle beats the timeout
    btn_next = 1'b1;
    wait_state(3, 20);
    btn_next = 1'b0;
    cyc(43);
    btn_next = 1'b1;
    cyc(6);
    lit("late_evt_hold", 3);
    cyc(1);
    lit("late_evt_4", 4);
    btn_next = 1'b0;
    cyc(10);

`ifdef MODE_SKIP_EN
    rst = 1'b0; cyc(2); rst = 1'b1; cyc(2);
    lit("skip_sleep", 1);
    mode_en_tb = 5'b10101;
    press(1); lit("skip_3", 3);
    press(1); lit("skip_5", 5);
    press(1); lit("skip_7", 7);
    press(1); lit("skip_wrap_3", 3);
    press(2); lit("skip_prev_7", 7);
    mode_en_tb = '0;
    cyc(1);
    lit("skip_none_1", 1);
    mode_en_tb = '1;
    cyc(2);
`endif

    // random phase: the model checks every cycle
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(7, 0) == 0) btn_next = ~btn_next;
      if ($urandom_range(9, 0) == 0) btn_prev = ~btn_prev;
      if ($urandom_range(15, 0) == 0) btn_stop = ~btn_stop;
      rst_ok = ($urandom_range(3, 0) != 0);
      rst    = ($urandom_range(499, 0) != 0);
`ifdef MODE_SKIP_EN
      if ($urandom_range(99, 0) == 0) mode_en_tb = 5'($urandom_range(31, 0));
`endif
      cyc(1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
